// File: rtl/axi_pkg.sv
// Shared AXI-lite widths, response codes, slave FSM states and latency LFSR taps.
package axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // x^8 + x^6 + x^5 + x^4 + 1, bit 7 is the oldest stage
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_COLLECT,
        ST_WR_WAIT,
        ST_WR_RESP
    } state_e;

endpackage

// File: rtl/lat_lfsr.sv
// 8-bit Fibonacci LFSR that steps only when adv_i is high; its low nibble
// supplies the per-transaction response latency.
module lat_lfsr
    import axi_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv_i,
    output logic [3:0] lat_o
);

    logic [7:0] lfsr_q, lfsr_d;

    // NOTE: combinational blocks assign every output first so no path leaves a latch.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i) begin
            lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lat_o = lfsr_q[3:0];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-lite SRAM slave: serves one read or write at a time from a word-addressed
// array, with fixed or LFSR-random response latency.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int unsigned           DEPTH_WORDS = 4096,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter bit                    RAND_LAT    = 1'b1,
    parameter int unsigned           FIXED_LAT   = 1,
    parameter logic [7:0]            LFSR_SEED   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AXI_ADDR_W-3:0] DEPTH_LIM = (AXI_ADDR_W-2)'(DEPTH_WORDS);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    aw_got_q, aw_got_d;
    logic                    w_got_q, w_got_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [AXI_DATA_W-1:0]   wdata_q, wdata_d;
    logic [AXI_STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [AXI_DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [1:0]              bresp_q, bresp_d;

    logic [AXI_DATA_W-1:0]   mem [DEPTH_WORDS];

    logic                    ar_hs, aw_hs, w_hs;
    logic                    wr_done, wr_capture, rd_fire, wr_fire, in_wait;
    logic [AXI_ADDR_W-1:0]   offset;
    logic                    hit;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              lfsr_lat, lat;
    logic [1:0]              unused_offset_lsb;

    assign ar_hs      = arvalid & arready;
    assign aw_hs      = awvalid & awready;
    assign w_hs       = wvalid & wready;
    assign wr_done    = (aw_got_q | aw_hs) & (w_got_q | w_hs);
    assign wr_capture = wr_done & ((state_q == ST_IDLE) | (state_q == ST_WR_COLLECT));
    assign in_wait    = (state_q == ST_RD_WAIT) | (state_q == ST_WR_WAIT);
    assign rd_fire    = (state_q == ST_RD_WAIT) & (cnt_q == 4'd0);
    assign wr_fire    = (state_q == ST_WR_WAIT) & (cnt_q == 4'd0);

    // Offset compare on the full word offset so addresses below BASE_ADDR wrap out of range.
    assign offset            = addr_q - BASE_ADDR;
    assign hit               = offset[AXI_ADDR_W-1:2] < DEPTH_LIM;
    assign idx               = offset[IDX_W+1:2];
    assign unused_offset_lsb = offset[1:0];

    assign lat = RAND_LAT ? lfsr_lat : 4'(FIXED_LAT);

    lat_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lat_lfsr (
        .clk   (clk),
        .rst   (rst),
        .adv_i (ar_hs | wr_capture),
        .lat_o (lfsr_lat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_d = ST_RD_WAIT;
                end else if (wr_done) begin
                    state_d = ST_WR_WAIT;
                end else if (aw_hs | w_hs) begin
                    state_d = ST_WR_COLLECT;
                end
            end
            ST_RD_WAIT:    if (cnt_q == 4'd0) state_d = ST_RD_RESP;
            ST_RD_RESP:    if (rready)        state_d = ST_IDLE;
            ST_WR_COLLECT: if (wr_done)       state_d = ST_WR_WAIT;
            ST_WR_WAIT:    if (cnt_q == 4'd0) state_d = ST_WR_RESP;
            ST_WR_RESP:    if (bready)        state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // A pending read in IDLE masks AW/W so the read is always served first.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        rvalid  = (state_q == ST_RD_RESP);
        bvalid  = (state_q == ST_WR_RESP);
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    arready = 1'b1;
                    awready = !arvalid && !aw_got_q;
                    wready  = !arvalid && !w_got_q;
                end
                ST_WR_COLLECT: begin
                    awready = !aw_got_q;
                    wready  = !w_got_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        bresp_d  = bresp_q;

        if (ar_hs) begin
            addr_d = araddr;
        end else if (aw_hs) begin
            addr_d = awaddr;
        end
        if (w_hs) begin
            wdata_d = wdata;
            wstrb_d = wstrb;
        end

        if (ar_hs || wr_capture) begin
            cnt_d = lat;
        end else if (in_wait && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (wr_capture) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
        end else begin
            if (aw_hs) aw_got_d = 1'b1;
            if (w_hs)  w_got_d  = 1'b1;
        end

        if (rd_fire) begin
            rdata_d = hit ? mem[idx] : '0;
            rresp_d = hit ? RESP_OKAY : RESP_DECERR;
        end
        if (wr_fire) begin
            bresp_d = hit ? RESP_OKAY : RESP_DECERR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 4'd0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            bresp_q  <= RESP_OKAY;
        end else begin
            cnt_q    <= cnt_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bresp_q  <= bresp_d;
        end
    end

    // NOTE: the array is never reset; contents survive rst and only the write port touches it.
    always_ff @(posedge clk) begin
        if (wr_fire && hit && !rst) begin
            for (int i = 0; i < AXI_STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign bresp = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: drivers push expected responses from a
// word-array/LFSR reference model, a negedge monitor pops and compares them.
module tb_axi_sram_slave;

    localparam int          DEPTH  = 256;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [7:0]  SEED   = 8'hA5;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  DECERR = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0;
    logic        rready = 1'b0, bready = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        arready, awready, wready, rvalid, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    axi_sram_slave #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .RAND_LAT    (1'b1),
        .FIXED_LAT   (1),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake, expected one within bound (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          due;
    } exp_t;

    exp_t        rq[$];
    exp_t        bq[$];
    logic [31:0] mem_m [DEPTH];
    logic [7:0]  lfsr_m = SEED;

    function automatic bit in_range(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 4 * DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // Latency is the LFSR's low nibble at acceptance; the LFSR then steps once.
    function automatic int take_lat();
        int l;
        l = int'(lfsr_m[3:0]);
        lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
        return l;
    endfunction

    // ---------------- monitor ----------------
    bit   rv_prev = 1'b0, bv_prev = 1'b0;
    bit   r_armed = 1'b0, b_armed = 1'b0;
    exp_t cur_r, cur_b;

    always @(negedge clk) begin
        if (rvalid) begin
            if (!rv_prev) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected: got rvalid, expected none (cycle %0d)", cyc);
                end else begin
                    cur_r   = rq.pop_front();
                    r_armed = 1'b1;
                    check("r_latency", cyc, cur_r.due);
                end
            end
            if (r_armed) begin
                check("r_data", rdata, cur_r.data);
                check("r_resp", rresp, cur_r.resp);
            end
            check("r_busy_ready", {arready, awready, wready}, 3'b000);
        end else begin
            r_armed = 1'b0;
        end
        rv_prev = rvalid;

        if (bvalid) begin
            if (!bv_prev) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got bvalid, expected none (cycle %0d)", cyc);
                end else begin
                    cur_b   = bq.pop_front();
                    b_armed = 1'b1;
                    check("b_latency", cyc, cur_b.due);
                end
            end
            if (b_armed) check("b_resp", bresp, cur_b.resp);
            check("b_busy_ready", {arready, awready, wready}, 3'b000);
        end else begin
            b_armed = 1'b0;
        end
        bv_prev = bvalid;
    end

    // ---------------- drivers ----------------
    task automatic finish_resp(input bit is_read, input int hold);
        int n;
        bit seen;
        n = 0;
        do begin
            @(negedge clk);
            seen = is_read ? rvalid : bvalid;
            n++;
        end while (!seen && n < 100);
        if (!seen) begin
            timeout(is_read ? "r_valid_wait" : "b_valid_wait");
            return;
        end
        repeat (hold) @(posedge clk);
        #1;
        if (is_read) rready = 1'b1;
        else         bready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        int   n;
        bit   hs;
        exp_t e;
        araddr  = addr;
        arvalid = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = arready;
            if (hs) check("ar_priority", {awready, wready}, 2'b00);
            @(posedge clk);
            n++;
        end
        #1 arvalid = 1'b0;
        if (!hs) begin
            timeout("ar_handshake");
            return;
        end
        e.resp = in_range(addr) ? OKAY : DECERR;
        e.data = in_range(addr) ? mem_m[word_of(addr)] : 32'h0;
        e.due  = cyc + take_lat() + 1;
        rq.push_back(e);
        finish_resp(1'b1, hold);
    endtask

    // lead > 0: W raised lead cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int hold);
        bit          aw_done, w_done;
        int          aw_c, w_c, w;
        exp_t        e;
        logic [31:0] word;
        aw_done = 1'b0;
        w_done  = 1'b0;
        aw_c    = 0;
        w_c     = 0;
        fork
            begin : aw_branch
                int n;
                bit hs;
                n  = 0;
                hs = 1'b0;
                if (lead > 0) repeat (lead) @(posedge clk);
                #1;
                awaddr  = addr;
                awvalid = 1'b1;
                while (!hs && n < 100) begin
                    @(negedge clk);
                    hs = awready;
                    @(posedge clk);
                    n++;
                end
                if (hs) aw_done = 1'b1;
                #1 awvalid = 1'b0;
                aw_c = cyc;
                if (!hs) timeout("aw_handshake");
                else if (!w_done) begin
                    @(negedge clk);
                    check("collect_aw_held", {awready, wready}, 2'b01);
                end
            end
            begin : w_branch
                int n;
                bit hs;
                n  = 0;
                hs = 1'b0;
                if (lead < 0) repeat (-lead) @(posedge clk);
                #1;
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
                while (!hs && n < 100) begin
                    @(negedge clk);
                    hs = wready;
                    @(posedge clk);
                    n++;
                end
                if (hs) w_done = 1'b1;
                #1 wvalid = 1'b0;
                w_c = cyc;
                if (!hs) timeout("w_handshake");
                else if (!aw_done) begin
                    @(negedge clk);
                    check("collect_w_held", {awready, wready}, 2'b10);
                end
            end
        join
        if (!(aw_done && w_done)) return;
        if (in_range(addr)) begin
            w    = word_of(addr);
            word = mem_m[w];
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) word[8*i +: 8] = data[8*i +: 8];
            end
            mem_m[w] = word;
        end
        e.resp = in_range(addr) ? OKAY : DECERR;
        e.data = 32'h0;
        e.due  = ((aw_c > w_c) ? aw_c : w_c) + take_lat() + 1;
        bq.push_back(e);
        finish_resp(1'b0, hold);
    endtask

    function automatic logic [31:0] pick_addr();
        int          s;
        logic [31:0] oor [4];
        oor[0] = 32'h0000_0000;
        oor[1] = BASE - 32'd4;
        oor[2] = BASE + 32'(4 * DEPTH);
        oor[3] = 32'h9000_0000;
        s = $urandom_range(0, 9);
        if (s < 8) return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if (s == 8) return oor[$urandom_range(0, 3)];
        return BASE + 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish, expected end before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit hs;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {arready, awready, wready}, 3'b000);
        check("rst_valid", {rvalid, bvalid}, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_resp", {rresp, bresp}, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {arready, awready, wready}, 3'b111);
        @(posedge clk);
        #1;

        // basic write then read-back
        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        do_read (BASE + 32'h10, 0);

        // partial strobes, AW ahead of W
        do_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 0, 1);
        do_write(BASE + 32'h20, 32'hAABB_CCDD, 4'h5, -2, 0);
        do_read (BASE + 32'h20, 0);

        // W three cycles ahead of AW
        do_write(BASE + 32'h30, 32'hCAFE_F00D, 4'hF, 3, 0);
        do_read (BASE + 32'h30, 0);

        // read back-pressure
        do_read (BASE + 32'h10, 5);

        // out-of-range accesses must not disturb the array
        do_write(BASE, 32'h0BAD_F00D, 4'hF, 0, 0);
        do_read (32'h0000_0000, 0);
        do_write(32'h9000_0000, 32'h1234_5678, 4'hF, 0, 0);
        do_write(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 1, 2);
        do_write(BASE - 32'd4, 32'hFFFF_FFFF, 4'hF, -1, 0);
        do_read (BASE, 0);

        // empty strobe writes nothing
        do_write(BASE + 32'h20, 32'hFFFF_FFFF, 4'h0, 0, 0);
        do_read (BASE + 32'h20, 0);

        // simultaneous AR and AW/W in IDLE: read goes first
        fork
            do_read (BASE + 32'h10, 2);
            do_write(BASE + 32'h10, 32'h5555_AAAA, 4'hF, 0, 0);
        join
        do_read(BASE + 32'h10, 0);

        // fill the random window and the top word, then random traffic
        for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0);
        do_write(BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hF, 0, 0);
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            int          lead;
            a    = pick_addr();
            lead = int'($urandom_range(0, 6)) - 3;
            if ($urandom_range(0, 2) == 0) do_read(a, int'($urandom_range(0, 3)));
            else do_write(a, $urandom, 4'($urandom_range(0, 15)), lead, int'($urandom_range(0, 3)));
        end

        // reset while a read waits: no response may follow
        araddr  = BASE + 32'h10;
        arvalid = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = arready;
            @(posedge clk);
            n++;
        end
        #1;
        arvalid = 1'b0;
        if (!hs) timeout("ar_before_reset");
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {rvalid, bvalid}, 2'b00);
        check("mid_rst_ready", {arready, awready, wready}, 3'b000);
        check("mid_rst_rdata", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        lfsr_m = SEED;
        repeat (25) @(posedge clk);
        #1;

        // LFSR restarts from its seed after reset
        do_read(BASE + 32'h10, 0);
        do_read(BASE + 32'(4 * (DEPTH - 1)), 1);

        repeat (5) @(posedge clk);
        check("r_queue_drained", rq.size(), 0);
        check("b_queue_drained", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
AXI-lite memory slave that sits directly downstream of the fetch/LSU bus arbiter and terminates its single slave port (s0).
- Backs a word-addressed internal SRAM array.
- Inserts fixed or LFSR-random response latency so that upstream handshake corner cases are exercised.
- Serves one transaction at a time, either a read or a write.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; byte address range is BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1
BASE_ADDR, 32'h8000_0000, byte address of word 0
RAND_LAT, 1, 1 = latency taken from LFSR; 0 = latency is FIXED_LAT
FIXED_LAT, 1, delay in cycles between address/data capture and response valid (0..15)
LFSR_SEED, 8'hA5, nonzero reset value of the 8-bit LFSR

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
araddr  in  32  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  32  read data
rresp  out  2  read response (00 OKAY, 11 DECERR)
rvalid  out  1  read data valid
rready  in  1  read data ready
awaddr  in  32  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  32  write data
wstrb  in  4  byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response (00 OKAY, 11 DECERR)
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset (rst=1, asynchronous): FSM goes to IDLE; delay counter 0; LFSR = LFSR_SEED; aw_got/w_got flags 0.
- Outputs during reset: rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, arready=awready=wready=0. Memory contents are not cleared.
- Reset asserted mid-transaction aborts it silently, with no response and no write.
- States:
  - IDLE: accepting requests.
  - RD_WAIT, RD_RESP: read in progress.
  - WR_COLLECT: one of AW/W held, waiting for the other.
  - WR_WAIT, WR_RESP: write in progress.
- Ready rules:
  - arready = (state==IDLE).
  - awready = (state==IDLE or WR_COLLECT) and !aw_got.
  - wready = (state==IDLE or WR_COLLECT) and !w_got.
- IDLE priority: if arvalid is high, accept the read and leave AW/W un-accepted that cycle, even if they are valid. awready/wready are forced to 0 in any cycle where arvalid=1 in IDLE.
- Read path:
  - On the AR handshake, latch the address and load the counter with lat = RAND_LAT ? lfsr[3:0] : FIXED_LAT, then go to RD_WAIT.
  - RD_WAIT decrements to 0. When the counter is 0, the array is read, rdata/rresp are registered, rvalid=1, and the state moves to RD_RESP.
  - With lat=0, rvalid rises exactly 1 cycle after the AR handshake. The general latency is lat+1 cycles.
  - RD_RESP holds rdata, rresp and rvalid stable until rready. The handshake cycle returns to IDLE, rvalid drops next cycle, and a new AR may be accepted in that next cycle.
- Write path:
  - AW and W may handshake in the same cycle or in either order.
  - Only one handshaked → WR_COLLECT.
  - Both handshaked → load counter (same lat rule) → WR_WAIT.
  - At counter 0: array bytes are written where wstrb[i]=1 (byte i = wdata[8i+7:8i]), then bvalid=1 → WR_RESP.
  - bvalid is held until bready; then return to IDLE.
  - wstrb=0 is legal: nothing is written and the response is OKAY.
- Address decode:
  - word index = (addr-BASE_ADDR)>>2; addr[1:0] is ignored.
  - Address outside the range → DECERR, rdata=0, no array write. Latency is identical to an in-range access.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. It advances on every AR or completed AW+W capture, never on idle cycles, so the latency sequence is deterministic for a given seed.
- Array read and write never occur in the same cycle.

Decomposition:
- Shared package axi_pkg: AXI_ADDR_W=32, AXI_DATA_W=32, AXI_STRB_W=4, RESP_OKAY=2'b00, RESP_DECERR=2'b11, plus the state enum typedef.
- One sub-module: lat_lfsr (8-bit LFSR with advance enable; outputs lfsr[3:0]).

Test Plan:
- RAND_LAT=0, FIXED_LAT=0: write 0xDEADBEEF to 0x8000_0010 with wstrb=0xF, then read it back → bresp=00 then rvalid 1 cycle after AR with rdata=0xDEADBEEF, rresp=00.
- Partial strobe: write 0x11223344 with wstrb=0xF, then 0xAABBCCDD with wstrb=0x5, same address → read returns 0x11BB33DD.
- W before AW: wvalid driven 3 cycles before awvalid → wready pulses first, state sits in WR_COLLECT, write completes correctly, exactly one bvalid.
- Back-pressure: hold rready=0 for 5 cycles after rvalid → rvalid and rdata stable for all 5 cycles; arready=0 throughout.
- Out of range: read 0x0000_0000 and write 0x9000_0000 → rresp=11 with rdata=0, bresp=11, and the array is unchanged.
- Simultaneous arvalid and awvalid in IDLE → read served first and awready stays 0 until after the R handshake. With RAND_LAT=1, measured latencies match a reference LFSR model seeded with 0xA5. Asserting rst during RD_WAIT → rvalid=0 immediately and no response afterwards.
